// File: rtl/store_write_buffer.sv
// ---------------------------------------------------------------------------
// store_write_buffer
//
// Post-retirement store buffer between the store queue and the D-cache.
// Retired stores (up to SWB_IN per cycle) are kept in program order in a
// circular FIFO. They drain to the D-cache one per cycle through a
// valid/ready handshake. While they wait, they stay visible to loads
// through a byte-granular forwarding lookup.
//
// Optional feature (compile-time macro SWB_COALESCE_EN):
//   The lowest-numbered valid write-back port may merge into the youngest
//   buffered entry when both target the same 32-bit word and that entry is
//   not the head. The merged store consumes no slot.
//   When the macro is undefined, no merge logic is built.
//
// Parameters
//   SWB_DEPTH  number of entries (power of 2, >= 4)
//   SWB_IN     number of write-back ports
//
// Ports
//   clock            rising-edge clock
//   reset            synchronous, active-low
//   cache_wb         retired stores; .ready marks a valid store
//   free_slots       SWB_DEPTH - count (does not credit a same-cycle drain)
//   empty            buffer holds no stores
//   overflow         sticky: a valid store was dropped for lack of a slot
//   dc_req_valid     head entry is presented to the D-cache
//   dc_req_addr      head entry address
//   dc_req_data      head entry data
//   dc_req_be        head entry byte enables
//   dc_req_ready     D-cache accepts the head this cycle
//   ld_lookup_valid  load forwarding probe valid
//   ld_lookup_addr   load address (word compare on [31:2])
//   ld_fwd_data      forwarded bytes; uncovered lanes read 0
//   ld_fwd_bytes     per-byte hit mask
// ---------------------------------------------------------------------------
package swb_pkg;
  typedef struct packed {
    logic        ready;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  usebytes;
  } SQ_ENTRY_PACKET;
endpackage

module store_write_buffer
  import swb_pkg::*;
#(
  parameter int SWB_DEPTH = 8,
  parameter int SWB_IN    = 3
) (
  input  logic                           clock,
  input  logic                           reset,
  input  SQ_ENTRY_PACKET [SWB_IN-1:0]    cache_wb,
  output logic [$clog2(SWB_DEPTH):0]     free_slots,
  output logic                           empty,
  output logic                           overflow,
  output logic                           dc_req_valid,
  output logic [31:0]                    dc_req_addr,
  output logic [31:0]                    dc_req_data,
  output logic [3:0]                     dc_req_be,
  input  logic                           dc_req_ready,
  input  logic                           ld_lookup_valid,
  input  logic [31:0]                    ld_lookup_addr,
  output logic [31:0]                    ld_fwd_data,
  output logic [3:0]                     ld_fwd_bytes
);

  localparam int PTR_W = $clog2(SWB_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  // Byte-lane merge: lanes selected by be take new_w, the others keep old_w.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  be);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    end
    return r;
  endfunction

  // Buffer state
  logic [31:0]          ent_addr_p1 [SWB_DEPTH];
  logic [31:0]          ent_data_p1 [SWB_DEPTH];
  logic [3:0]           ent_be_p1   [SWB_DEPTH];
  logic [SWB_DEPTH-1:0] ent_vld_p1;
  logic [PTR_W-1:0]     head_p1;
  logic [PTR_W-1:0]     tail_p1;
  logic [CNT_W-1:0]     count_p1;
  logic                 ovf_p1;

  // Enqueue/dequeue decisions for the current cycle
  logic [SWB_IN-1:0]    acc_p0;
  logic [PTR_W-1:0]     slot_p0 [SWB_IN];
  logic [CNT_W-1:0]     n_enq_p0;
  logic                 drop_p0;
  logic                 deq_p0;
  logic [PTR_W-1:0]     young_p0;

`ifdef SWB_COALESCE_EN
  logic                 merge_p0;
  logic [31:0]          merge_data_p0;
  logic [3:0]           merge_be_p0;
  logic                 seen_p0;
`endif

  logic [PTR_W-1:0]     fwd_idx_p0;
  logic                 unused_lookup_lsb;

  assign unused_lookup_lsb = ^ld_lookup_addr[1:0];

  assign free_slots   = CNT_W'(SWB_DEPTH) - count_p1;
  assign empty        = (count_p1 == '0);
  assign overflow     = ovf_p1;
  assign dc_req_valid = (count_p1 != '0);
  assign dc_req_addr  = ent_addr_p1[head_p1];
  assign dc_req_data  = ent_data_p1[head_p1];
  assign dc_req_be    = ent_be_p1[head_p1];
  assign deq_p0       = dc_req_valid && dc_req_ready;
  assign young_p0     = tail_p1 - PTR_ONE;

  // ---- stage 0: compact valid ports into consecutive slots from tail ----
  // n_enq_p0 doubles as the running rank; a store whose rank reaches
  // free_slots has no slot and is dropped.
  always_comb begin
    acc_p0   = '0;
    n_enq_p0 = '0;
    drop_p0  = 1'b0;
    for (int i = 0; i < SWB_IN; i++) slot_p0[i] = '0;
`ifdef SWB_COALESCE_EN
    merge_p0      = 1'b0;
    merge_data_p0 = ent_data_p1[young_p0];
    merge_be_p0   = ent_be_p1[young_p0];
    seen_p0       = 1'b0;
`endif
    for (int i = 0; i < SWB_IN; i++) begin
      if (cache_wb[i].ready) begin
`ifdef SWB_COALESCE_EN
        // Only the first valid port may merge, and never into the head,
        // which could be leaving for the cache this very cycle.
        if (!seen_p0 && (count_p1 > CNT_ONE) &&
            (cache_wb[i].addr[31:2] == ent_addr_p1[young_p0][31:2])) begin
          merge_p0      = 1'b1;
          merge_data_p0 = merge_bytes(ent_data_p1[young_p0], cache_wb[i].data,
                                      cache_wb[i].usebytes);
          merge_be_p0   = ent_be_p1[young_p0] | cache_wb[i].usebytes;
        end else
`endif
        if (n_enq_p0 < free_slots) begin
          acc_p0[i]  = 1'b1;
          slot_p0[i] = tail_p1 + n_enq_p0[PTR_W-1:0];
          n_enq_p0   = n_enq_p0 + CNT_ONE;
        end else begin
          drop_p0 = 1'b1;
        end
`ifdef SWB_COALESCE_EN
        seen_p0 = 1'b1;
`endif
      end
    end
  end

  // ---- stage 1: buffer state update ----
  always_ff @(posedge clock) begin
    if (!reset) begin
      ent_vld_p1 <= '0;
      head_p1    <= '0;
      tail_p1    <= '0;
      count_p1   <= '0;
      ovf_p1     <= 1'b0;
    end else begin
      for (int i = 0; i < SWB_IN; i++) begin
        if (acc_p0[i]) ent_vld_p1[slot_p0[i]] <= 1'b1;
      end
      // The head is occupied whenever deq_p0 is set, so it never collides
      // with a freshly written slot.
      if (deq_p0) ent_vld_p1[head_p1] <= 1'b0;
      head_p1  <= head_p1 + PTR_W'(deq_p0);
      tail_p1  <= tail_p1 + n_enq_p0[PTR_W-1:0];
      count_p1 <= count_p1 + n_enq_p0 - CNT_W'(deq_p0);
      if (drop_p0) ovf_p1 <= 1'b1;
    end
  end

  // Entry payload carries no reset; the valid bits alone qualify it.
  always_ff @(posedge clock) begin
    for (int i = 0; i < SWB_IN; i++) begin
      if (acc_p0[i]) begin
        ent_addr_p1[slot_p0[i]] <= cache_wb[i].addr;
        ent_data_p1[slot_p0[i]] <= cache_wb[i].data;
        ent_be_p1[slot_p0[i]]   <= cache_wb[i].usebytes;
      end
    end
`ifdef SWB_COALESCE_EN
    if (merge_p0) begin
      ent_data_p1[young_p0] <= merge_data_p0;
      ent_be_p1[young_p0]   <= merge_be_p0;
    end
`endif
  end

  // ---- load forwarding: oldest to youngest, later matches overwrite ----
  always_comb begin
    ld_fwd_data  = '0;
    ld_fwd_bytes = '0;
    fwd_idx_p0   = '0;
    if (ld_lookup_valid) begin
      for (int k = 0; k < SWB_DEPTH; k++) begin
        fwd_idx_p0 = head_p1 + PTR_W'(k);
        if (ent_vld_p1[fwd_idx_p0] &&
            (ent_addr_p1[fwd_idx_p0][31:2] == ld_lookup_addr[31:2])) begin
          ld_fwd_data  = merge_bytes(ld_fwd_data, ent_data_p1[fwd_idx_p0],
                                     ent_be_p1[fwd_idx_p0]);
          ld_fwd_bytes = ld_fwd_bytes | ent_be_p1[fwd_idx_p0];
        end
      end
    end
  end

endmodule

// File: tb/tb_store_write_buffer.sv
// Testbench for store_write_buffer: a queue-based reference model is
// advanced every cycle and compared against the DUT outputs, plus directed
// scenarios with hand-computed literal expectations.
module tb_store_write_buffer;
  import swb_pkg::*;

  localparam int SWB_DEPTH = 8;
  localparam int SWB_IN    = 3;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } ment_t;

  logic                        clock;
  logic                        reset;
  SQ_ENTRY_PACKET [SWB_IN-1:0] cache_wb;
  logic [$clog2(SWB_DEPTH):0]  free_slots;
  logic                        empty;
  logic                        overflow;
  logic                        dc_req_valid;
  logic [31:0]                 dc_req_addr;
  logic [31:0]                 dc_req_data;
  logic [3:0]                  dc_req_be;
  logic                        dc_req_ready;
  logic                        ld_lookup_valid;
  logic [31:0]                 ld_lookup_addr;
  logic [31:0]                 ld_fwd_data;
  logic [3:0]                  ld_fwd_bytes;

  int    n_chk = 0;
  int    n_fail = 0;
  ment_t mq[$];
  bit    movf = 0;
  bit    model_ok = 0;

  store_write_buffer #(.SWB_DEPTH(SWB_DEPTH), .SWB_IN(SWB_IN)) dut (
    .clock          (clock),
    .reset          (reset),
    .cache_wb       (cache_wb),
    .free_slots     (free_slots),
    .empty          (empty),
    .overflow       (overflow),
    .dc_req_valid   (dc_req_valid),
    .dc_req_addr    (dc_req_addr),
    .dc_req_data    (dc_req_data),
    .dc_req_be      (dc_req_be),
    .dc_req_ready   (dc_req_ready),
    .ld_lookup_valid(ld_lookup_valid),
    .ld_lookup_addr (ld_lookup_addr),
    .ld_fwd_data    (ld_fwd_data),
    .ld_fwd_bytes   (ld_fwd_bytes)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Compare DUT against the model, then advance the model by the coming edge.
  task automatic compare_and_step();
    int          n;
    int          free;
    bit          deq;
    bit          merged;
    logic [31:0] ed;
    logic [3:0]  eb;
    ment_t       nq[$];
    ment_t       t;
`ifdef SWB_COALESCE_EN
    bit          first;
`endif
    if (model_ok) begin
      n = mq.size();
      chk("cyc_free", 32'(free_slots), 32'(SWB_DEPTH - n));
      chk("cyc_empty", 32'(empty), 32'(n == 0));
      chk("cyc_dcv", 32'(dc_req_valid), 32'(n != 0));
      chk("cyc_ovf", 32'(overflow), 32'(movf));
      if (n != 0) begin
        chk("cyc_dc_addr", dc_req_addr, mq[0].addr);
        chk("cyc_dc_data", dc_req_data, mq[0].data);
        chk("cyc_dc_be", 32'(dc_req_be), 32'(mq[0].be));
      end
      ed = '0;
      eb = '0;
      if (ld_lookup_valid) begin
        foreach (mq[i]) begin
          if (mq[i].addr[31:2] == ld_lookup_addr[31:2]) begin
            for (int b = 0; b < 4; b++) begin
              if (mq[i].be[b]) begin
                ed[8*b +: 8] = mq[i].data[8*b +: 8];
                eb[b] = 1'b1;
              end
            end
          end
        end
      end
      chk("cyc_fwd_bytes", 32'(ld_fwd_bytes), 32'(eb));
      chk("cyc_fwd_data", ld_fwd_data, ed);
    end
    if (!reset) begin
      mq.delete();
      movf = 0;
      model_ok = 1;
    end else if (model_ok) begin
      free = SWB_DEPTH - mq.size();
      deq = (mq.size() != 0) && dc_req_ready;
`ifdef SWB_COALESCE_EN
      first = 1;
`endif
      for (int p = 0; p < SWB_IN; p++) begin
        if (cache_wb[p].ready) begin
          merged = 0;
`ifdef SWB_COALESCE_EN
          if (first && mq.size() >= 2 &&
              mq[mq.size()-1].addr[31:2] == cache_wb[p].addr[31:2]) begin
            t = mq[mq.size()-1];
            for (int b = 0; b < 4; b++)
              if (cache_wb[p].usebytes[b]) t.data[8*b +: 8] = cache_wb[p].data[8*b +: 8];
            t.be = t.be | cache_wb[p].usebytes;
            mq[mq.size()-1] = t;
            merged = 1;
          end
          first = 0;
`endif
          if (!merged) begin
            if (nq.size() < free) begin
              t.addr = cache_wb[p].addr;
              t.data = cache_wb[p].data;
              t.be   = cache_wb[p].usebytes;
              nq.push_back(t);
            end else begin
              movf = 1;
            end
          end
        end
      end
      if (deq) void'(mq.pop_front());
      foreach (nq[i]) mq.push_back(nq[i]);
    end
  endtask

  always @(negedge clock) compare_and_step();

  task automatic tick();
    @(posedge clock);
    #1;
    cache_wb = '0;
  endtask

  task automatic put(input int p, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] be);
    cache_wb[p].ready    = 1'b1;
    cache_wb[p].addr     = a;
    cache_wb[p].data     = d;
    cache_wb[p].usebytes = be;
  endtask

  task automatic reset_pulse();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic fill8(input logic [31:0] base);
    int k;
    for (int c = 0; c < 3; c++) begin
      for (int p = 0; p < 3; p++) begin
        k = c * 3 + p;
        if (k < 8) put(p, base + 32'(4 * k), 32'hD000_0000 + 32'(k), 4'hF);
      end
      tick();
    end
  endtask

  int exp_free6;

  initial begin
    reset = 1'b0;
    cache_wb = '0;
    dc_req_ready = 1'b0;
    ld_lookup_valid = 1'b0;
    ld_lookup_addr = '0;

    // Reset held two cycles
    tick();
    tick();
    reset = 1'b1;
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_free", 32'(free_slots), 32'd8);
    chk("rst_dcv", 32'(dc_req_valid), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_fwd", 32'(ld_fwd_bytes), 32'd0);

    // Ports 0 and 2, then drain
    put(0, 32'h100, 32'h1111_1111, 4'hF);
    put(2, 32'h200, 32'h2222_2222, 4'hF);
    tick();
    chk("t2_free", 32'(free_slots), 32'd6);
    chk("t2_addr", dc_req_addr, 32'h100);
    chk("t2_data", dc_req_data, 32'h1111_1111);
    dc_req_ready = 1'b1;
    tick();
    chk("t2_addr2", dc_req_addr, 32'h200);
    chk("t2_data2", dc_req_data, 32'h2222_2222);
    tick();
    chk("t2_empty", 32'(empty), 32'd1);
    dc_req_ready = 1'b0;

    // Fill, overflow, drain across wrap
    fill8(32'h1000);
    chk("t3_full", 32'(free_slots), 32'd0);
    put(0, 32'h5000, 32'h5555_5555, 4'hF);
    tick();
    chk("t3_ovf", 32'(overflow), 32'd1);
    chk("t3_full2", 32'(free_slots), 32'd0);
    dc_req_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk("t3_drain_addr", dc_req_addr, 32'h1000 + 32'(4 * k));
      tick();
    end
    chk("t3_empty", 32'(empty), 32'd1);
    dc_req_ready = 1'b0;
    reset_pulse();
    chk("t3_ovf_clr", 32'(overflow), 32'd0);

    // Youngest store wins per byte
    put(0, 32'h300, 32'hAAAA_AAAA, 4'h3);
    put(1, 32'h300, 32'hBBBB_BBBB, 4'h2);
    tick();
    ld_lookup_valid = 1'b1;
    ld_lookup_addr = 32'h302;
    #1;
    chk("t4_bytes", 32'(ld_fwd_bytes), 32'h3);
    chk("t4_data", ld_fwd_data, 32'h0000_BBAA);
    ld_lookup_valid = 1'b0;
    #1;
    chk("t4_novalid", 32'(ld_fwd_bytes), 32'h0);
    dc_req_ready = 1'b1;
    tick();
    tick();
    dc_req_ready = 1'b0;
    chk("t4_empty", 32'(empty), 32'd1);

    // Full with simultaneous drain: store dropped
    fill8(32'h2000);
    chk("t5_full", 32'(free_slots), 32'd0);
    dc_req_ready = 1'b1;
    put(0, 32'h6000, 32'h6666_6666, 4'hF);
    tick();
    chk("t5_ovf", 32'(overflow), 32'd1);
    chk("t5_cnt7", 32'(free_slots), 32'd1);
    put(0, 32'h6004, 32'h6767_6767, 4'hF);
    tick();
    chk("t5_cnt7b", 32'(free_slots), 32'd1);
    dc_req_ready = 1'b0;
    reset_pulse();

    // Coalescing into the youngest entry
    put(0, 32'h10, 32'h0, 4'hF);
    put(1, 32'h20, 32'h0, 4'hF);
    put(2, 32'h400, 32'h0000_00CC, 4'h1);
    tick();
    put(0, 32'h401, 32'h0000_DD00, 4'h2);
    tick();
`ifdef SWB_COALESCE_EN
    exp_free6 = 5;
`else
    exp_free6 = 4;
`endif
    chk("t6_free", 32'(free_slots), 32'(exp_free6));
    ld_lookup_valid = 1'b1;
    ld_lookup_addr = 32'h400;
    #1;
    chk("t6_bytes", 32'(ld_fwd_bytes), 32'h3);
    chk("t6_data", ld_fwd_data, 32'h0000_DDCC);
    ld_lookup_valid = 1'b0;
    reset_pulse();

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      dc_req_ready = ($urandom % 4) != 0;
      for (int p = 0; p < SWB_IN; p++) begin
        if (($urandom % 5) < 2)
          put(p, 32'h40 + 32'(4 * ($urandom % 4)) + 32'($urandom % 4),
              $urandom, 4'($urandom % 16));
      end
      ld_lookup_valid = $urandom % 2;
      ld_lookup_addr = 32'h40 + 32'(4 * ($urandom % 5)) + 32'($urandom % 4);
      reset = (($urandom % 300) != 0);
      tick();
    end
    reset = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
